branch_target_predictor: RTL and testbench

Front-end branch/jump unit for the pipelined RV32 core. It decodes the control-transfer immediate (B-type, JAL, and, when enabled, compressed CB/CJ forms) from the fetched instruction and computes the target as `pc + imm`. It also predicts conditional-branch direction from a direct-mapped table of 2-bit saturating counters, which the EX stage trains with resolved outcomes. It sits between IF and ID and feeds the PC-select mux one cycle after lookup.

---
 rtl/branch_target_predictor_if.sv | 31 +++
 rtl/branch_target_predictor.sv | 119 +++++++++++
 tb/tb_branch_target_predictor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// Lookup, prediction and training signals between IF/ID, the branch unit and EX.
// The master side drives lookups and updates; the slave side returns registered predictions.
interface branch_target_predictor_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            valid_i;
    logic [XLEN-1:0] pc_i;
    logic [31:0]     instruction_i;
    logic            valid_o;
    logic            is_branch_o;
    logic            is_jump_o;
    logic            taken_o;
    logic [XLEN-1:0] target_o;
    logic [XLEN-1:0] fallthrough_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;

    modport master (
        output stall_i, valid_i, pc_i, instruction_i,
        output upd_valid_i, upd_pc_i, upd_taken_i,
        input  valid_o, is_branch_o, is_jump_o, taken_o, target_o, fallthrough_o
    );

    modport slave (
        input  stall_i, valid_i, pc_i, instruction_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i,
        output valid_o, is_branch_o, is_jump_o, taken_o, target_o, fallthrough_o
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Branch/jump target decode plus 2-bit counter direction predictor; RVC_BRANCH_EN adds compressed CB/CJ forms.
// Latency: one cycle from lookup to registered outputs; counter table trained by EX on the same edge.
// Backpressure: stall holds the output stage and drops that cycle's lookup; table updates still apply.
module branch_target_predictor #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_target_predictor_if.slave bus
);
    localparam int IDXW = $clog2(BHT_DEPTH);

    logic [1:0]      bht [BHT_DEPTH];
    logic [31:0]     instr;
    logic            is_br;
    logic            is_jmp;
    logic            pred_taken;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] fallthrough;
    logic [XLEN-1:0] target;
    logic [IDXW-1:0] lk_idx;
    logic [IDXW-1:0] up_idx;
    logic            unused_upd_bits;

    assign instr = bus.instruction_i;

    always_comb begin
        is_br  = 1'b0;
        is_jmp = 1'b0;
        imm    = '0;
        step   = XLEN'(4);
        case (instr[6:0])
            7'b1100011: begin
                is_br = 1'b1;
                imm   = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            end
            7'b1101111: begin
                is_jmp = 1'b1;
                imm    = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            end
            default: ;
        endcase
`ifdef RVC_BRANCH_EN
        // Any non-11 low pair is a 16-bit instruction; only quadrant 01 carries CB/CJ.
        if (instr[1:0] != 2'b11) begin
            step   = XLEN'(2);
            is_br  = 1'b0;
            is_jmp = 1'b0;
            imm    = '0;
            if (instr[1:0] == 2'b01) begin
                case (instr[15:13])
                    3'b101, 3'b001: begin
                        is_jmp = 1'b1;
                        imm    = {{(XLEN-12){instr[12]}}, instr[12], instr[8], instr[10:9],
                                  instr[6], instr[7], instr[2], instr[11], instr[5:3], 1'b0};
                    end
                    3'b110, 3'b111: begin
                        is_br = 1'b1;
                        imm   = {{(XLEN-9){instr[12]}}, instr[12], instr[6:5], instr[2],
                                 instr[11:10], instr[4:3], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
`endif
    end

`ifdef RVC_BRANCH_EN
    assign lk_idx = bus.pc_i[IDXW:1];
    assign up_idx = bus.upd_pc_i[IDXW:1];
`else
    assign lk_idx = bus.pc_i[IDXW+1:2];
    assign up_idx = bus.upd_pc_i[IDXW+1:2];
`endif
    assign unused_upd_bits = ^bus.upd_pc_i;

    assign fallthrough = bus.pc_i + step;
    assign target      = (is_br || is_jmp) ? bus.pc_i + imm : fallthrough;
    // Combinational read of the pre-edge counter gives read-before-write on index collisions.
    assign pred_taken  = is_jmp || (is_br && bht[lk_idx][1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_o       <= 1'b0;
            bus.is_branch_o   <= 1'b0;
            bus.is_jump_o     <= 1'b0;
            bus.taken_o       <= 1'b0;
            bus.target_o      <= '0;
            bus.fallthrough_o <= '0;
        end else if (!bus.stall_i) begin
            bus.valid_o       <= bus.valid_i;
            bus.is_branch_o   <= bus.valid_i && is_br;
            bus.is_jump_o     <= bus.valid_i && is_jmp;
            bus.taken_o       <= bus.valid_i && pred_taken;
            bus.target_o      <= target;
            bus.fallthrough_o <= fallthrough;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (bus.upd_valid_i) begin
            if (bus.upd_taken_i && bht[up_idx] != 2'b11) begin
                bht[up_idx] <= bht[up_idx] + 2'b01;
            end else if (!bus.upd_taken_i && bht[up_idx] != 2'b00) begin
                bht[up_idx] <= bht[up_idx] - 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: decode, wrap-around, counter training, stall and reset.
module tb_branch_target_predictor;
    localparam logic [31:0] BEQ_P8 = 32'h0000_0463;
    localparam logic [31:0] JAL_M4 = 32'hFFDF_F06F;
    localparam logic [31:0] C_J0   = 32'h0000_A001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    branch_target_predictor_if #(.XLEN(32)) bus ();

    branch_target_predictor #(.XLEN(32), .BHT_DEPTH(16), .CTR_INIT(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] ins);
        bus.valid_i       = 1'b1;
        bus.pc_i          = pc;
        bus.instruction_i = ins;
    endtask

    task automatic update(input logic en, input logic [31:0] pc, input logic tk);
        bus.upd_valid_i = en;
        bus.upd_pc_i    = pc;
        bus.upd_taken_i = tk;
    endtask

    task automatic expect_all(input string tag, input logic v, input logic br, input logic jmp,
                              input logic tk, input logic [31:0] tgt, input logic [31:0] ft);
        check({tag, ".valid"},  32'(bus.valid_o),     32'(v));
        check({tag, ".branch"}, 32'(bus.is_branch_o), 32'(br));
        check({tag, ".jump"},   32'(bus.is_jump_o),   32'(jmp));
        check({tag, ".taken"},  32'(bus.taken_o),     32'(tk));
        check({tag, ".target"}, bus.target_o,         tgt);
        check({tag, ".fall"},   bus.fallthrough_o,    ft);
    endtask

    initial begin
        // Reset with a live lookup, an update and a stall all presented: reset must win.
        bus.stall_i = 1'b1;
        lookup(32'h200, JAL_M4);
        update(1'b1, 32'h100, 1'b1);
        tick;
        tick;
        rst         = 1'b0;
        bus.stall_i = 1'b0;
        bus.valid_i = 1'b0;
        update(1'b0, 32'h0, 1'b0);
        expect_all("reset", 0, 0, 0, 0, 32'h0, 32'h0);

        lookup(32'h100, BEQ_P8);
        tick;
        expect_all("beq", 1, 1, 0, 0, 32'h108, 32'h104);

        lookup(32'h200, JAL_M4);
        tick;
        expect_all("jal", 1, 0, 1, 1, 32'h1FC, 32'h204);

        lookup(32'h0, JAL_M4);
        tick;
        expect_all("jal_wrap", 1, 0, 1, 1, 32'hFFFF_FFFC, 32'h4);

        bus.valid_i = 1'b0;
        tick;
        check("idle.valid", 32'(bus.valid_o), 32'h0);

        // Counter 01 -> 10 -> 11.
        update(1'b1, 32'h100, 1'b1);
        tick;
        tick;
        update(1'b0, 32'h100, 1'b0);
        lookup(32'h100, BEQ_P8);
        tick;
        check("train2.taken", 32'(bus.taken_o), 32'h1);

        // Saturate at 11, then one not-taken -> 10.
        bus.valid_i = 1'b0;
        update(1'b1, 32'h100, 1'b1);
        tick;
        tick;
        tick;
        update(1'b1, 32'h100, 1'b0);
        tick;
        update(1'b0, 32'h100, 1'b0);
        lookup(32'h100, BEQ_P8);
        tick;
        check("sat_hi.taken", 32'(bus.taken_o), 32'h1);

        // 10 -> 00 saturating low, then one taken -> 01.
        bus.valid_i = 1'b0;
        update(1'b1, 32'h100, 1'b0);
        tick;
        tick;
        tick;
        tick;
        update(1'b1, 32'h100, 1'b1);
        tick;
        update(1'b0, 32'h100, 1'b0);
        lookup(32'h100, BEQ_P8);
        tick;
        check("sat_lo.taken", 32'(bus.taken_o), 32'h0);

        // Same-cycle lookup and update: lookup sees 01, then 10.
        update(1'b1, 32'h100, 1'b1);
        tick;
        check("rbw.taken", 32'(bus.taken_o), 32'h0);
        check("rbw.valid", 32'(bus.valid_o), 32'h1);
        update(1'b0, 32'h100, 1'b0);
        tick;
        check("rbw_next.taken", 32'(bus.taken_o), 32'h1);

        // Neighbouring index is still untrained.
        lookup(32'h104, BEQ_P8);
        tick;
        check("idx1.taken", 32'(bus.taken_o), 32'h0);
        check("idx1.target", bus.target_o, 32'h10C);

        lookup(32'h200, JAL_M4);
        tick;
        expect_all("pre_stall", 1, 0, 1, 1, 32'h1FC, 32'h204);

        // Stall three cycles with changing inputs; an update in the first stall cycle (10 -> 11).
        bus.stall_i = 1'b1;
        lookup(32'h100, BEQ_P8);
        update(1'b1, 32'h100, 1'b1);
        tick;
        expect_all("stall1", 1, 0, 1, 1, 32'h1FC, 32'h204);
        update(1'b0, 32'h100, 1'b0);
        bus.valid_i = 1'b0;
        tick;
        expect_all("stall2", 1, 0, 1, 1, 32'h1FC, 32'h204);
        lookup(32'h104, BEQ_P8);
        tick;
        expect_all("stall3", 1, 0, 1, 1, 32'h1FC, 32'h204);
        bus.stall_i = 1'b0;
        lookup(32'h100, BEQ_P8);
        tick;
        expect_all("unstall", 1, 1, 0, 1, 32'h108, 32'h104);

        // 11 -> 10 keeps taken only if the stalled-cycle update landed.
        bus.valid_i = 1'b0;
        update(1'b1, 32'h100, 1'b0);
        tick;
        update(1'b0, 32'h100, 1'b0);
        lookup(32'h100, BEQ_P8);
        tick;
        check("stall_upd.taken", 32'(bus.taken_o), 32'h1);

        // Back to 11, then reset mid-operation with competing stall/update/lookup.
        bus.valid_i = 1'b0;
        update(1'b1, 32'h100, 1'b1);
        tick;
        rst         = 1'b1;
        bus.stall_i = 1'b1;
        lookup(32'h100, BEQ_P8);
        update(1'b1, 32'h100, 1'b1);
        tick;
        rst         = 1'b0;
        bus.stall_i = 1'b0;
        update(1'b0, 32'h100, 1'b0);
        expect_all("mid_reset", 0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        expect_all("post_reset", 1, 1, 0, 0, 32'h108, 32'h104);

        lookup(32'h300, C_J0);
        tick;
`ifdef RVC_BRANCH_EN
        expect_all("c_j", 1, 0, 1, 1, 32'h300, 32'h302);
`else
        expect_all("c_j", 1, 0, 0, 0, 32'h304, 32'h304);
`endif

        bus.valid_i = 1'b0;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
